// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU operation codes and result-class codes for the RV32IM execute stage.
package ex_stage_pkg;

  localparam int REG_W      = 32;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;
  localparam int REGADDR_W  = 5;
  localparam int INSTADDR_W = 32;

  typedef logic [REG_W-1:0]      reg_t;
  typedef logic [ALUOP_W-1:0]    alu_op_t;
  typedef logic [ALUSEL_W-1:0]   alu_sel_t;
  typedef logic [REGADDR_W-1:0]  reg_addr_t;
  typedef logic [INSTADDR_W-1:0] inst_addr_t;

  localparam alu_sel_t RES_NOP       = 3'd0;
  localparam alu_sel_t RES_LOGIC     = 3'd1;
  localparam alu_sel_t RES_SHIFT     = 3'd2;
  localparam alu_sel_t RES_ARITH     = 3'd3;
  localparam alu_sel_t RES_MUL       = 3'd4;
  localparam alu_sel_t RES_DIV       = 3'd5;
  localparam alu_sel_t RES_JUMP      = 3'd6;
  localparam alu_sel_t RES_LOADSTORE = 3'd7;

  localparam alu_op_t EXE_NOP    = 8'h00;
  localparam alu_op_t EXE_AND    = 8'h01;
  localparam alu_op_t EXE_OR     = 8'h02;
  localparam alu_op_t EXE_XOR    = 8'h03;
  localparam alu_op_t EXE_SLL    = 8'h04;
  localparam alu_op_t EXE_SRL    = 8'h05;
  localparam alu_op_t EXE_SRA    = 8'h06;
  localparam alu_op_t EXE_ADD    = 8'h07;
  localparam alu_op_t EXE_SUB    = 8'h08;
  localparam alu_op_t EXE_SLT    = 8'h09;
  localparam alu_op_t EXE_SLTU   = 8'h0A;
  localparam alu_op_t EXE_MUL    = 8'h0B;
  localparam alu_op_t EXE_MULH   = 8'h0C;
  localparam alu_op_t EXE_MULHSU = 8'h0D;
  localparam alu_op_t EXE_MULHU  = 8'h0E;
  localparam alu_op_t EXE_DIV    = 8'h0F;
  localparam alu_op_t EXE_DIVU   = 8'h10;
  localparam alu_op_t EXE_REM    = 8'h11;
  localparam alu_op_t EXE_REMU   = 8'h12;
  localparam alu_op_t EXE_JAL    = 8'h13;
  localparam alu_op_t EXE_JALR   = 8'h14;
  localparam alu_op_t EXE_LB     = 8'h15;
  localparam alu_op_t EXE_LH     = 8'h16;
  localparam alu_op_t EXE_LW     = 8'h17;
  localparam alu_op_t EXE_LBU    = 8'h18;
  localparam alu_op_t EXE_LHU    = 8'h19;
  localparam alu_op_t EXE_SB     = 8'h1A;
  localparam alu_op_t EXE_SH     = 8'h1B;
  localparam alu_op_t EXE_SW     = 8'h1C;

  // Opcodes are allocated densely from zero, so anything above the last store is unknown.
  function automatic logic aluop_known(input alu_op_t op);
    return (op <= EXE_SW);
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return (op == EXE_DIV) || (op == EXE_DIVU) || (op == EXE_REM) || (op == EXE_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle: decoded operands in, results and stall request out.
interface ex_stage_if;
  import ex_stage_pkg::*;

  alu_op_t    aluop_i;
  alu_sel_t   alusel_i;
  reg_t       opv1_i;
  reg_t       opv2_i;
  reg_addr_t  reg_waddr_i;
  logic       we_i;
  inst_addr_t link_addr_i;
  reg_t       mem_offset_i;
  logic [5:0] stall;

  reg_addr_t  reg_waddr_o;
  logic       we_o;
  reg_t       wdata_o;
  alu_op_t    aluop_o;
  reg_t       mem_addr_o;
  reg_t       mem_data_o;
  logic       stallreq_o;

  modport master (
    output aluop_i, alusel_i, opv1_i, opv2_i, reg_waddr_i, we_i,
           link_addr_i, mem_offset_i, stall,
    input  reg_waddr_o, we_o, wdata_o, aluop_o, mem_addr_o, mem_data_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, opv1_i, opv2_i, reg_waddr_i, we_i,
           link_addr_i, mem_offset_i, stall,
    output reg_waddr_o, we_o, wdata_o, aluop_o, mem_addr_o, mem_data_o, stallreq_o
  );

endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = REG_W,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            hold,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dsr;
  logic             neg_q;
  logic             neg_r;

  logic             dvd_neg;
  logic             dsr_neg;
  logic [XLEN-1:0]  dvd_abs;
  logic [XLEN-1:0]  dsr_abs;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN-1:0]  rem_step;
  logic             last_step;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // quo doubles as the dividend shift register: its MSB feeds the partial remainder.
  always_comb begin
    dvd_neg   = signed_op & dividend[XLEN-1];
    dsr_neg   = signed_op & divisor[XLEN-1];
    dvd_abs   = neg_if(dividend, dvd_neg);
    dsr_abs   = neg_if(divisor, dsr_neg);
    trial     = {rem, quo[XLEN-1]} - {1'b0, dsr};
    rem_step  = trial[XLEN-1:0];
    quo_step  = {quo[XLEN-2:0], 1'b1};
    if (trial[XLEN]) begin
      rem_step = {rem[XLEN-2:0], quo[XLEN-1]};
      quo_step = {quo[XLEN-2:0], 1'b0};
    end
    last_step = (cnt == CNT_W'(DIV_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quo   <= ALL_ONES;
              rem   <= dividend;
              state <= ST_DONE;
            end else if (signed_op && dividend == MIN_NEG && divisor == ALL_ONES) begin
              quo   <= MIN_NEG;
              rem   <= '0;
              state <= ST_DONE;
            end else begin
              quo   <= dvd_abs;
              rem   <= '0;
              dsr   <= dsr_abs;
              neg_q <= dvd_neg ^ dsr_neg;
              neg_r <= dvd_neg;
              cnt   <= '0;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (last_step) begin
            quo   <= neg_if(quo_step, neg_q);
            rem   <= neg_if(rem_step, neg_r);
            state <= ST_DONE;
          end else begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!hold) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign ready     = (state == ST_DONE);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU/shift/compare/multiply/link/address paths,
// plus an iterative divider that holds the front of the pipeline via stallreq_o.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = REG_W,
  parameter int DIV_CYCLES = XLEN
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0]   opv1;
  logic [XLEN-1:0]   opv2;
  alu_op_t           op;
  logic [SH_W-1:0]   shamt;
  logic              known;

  logic [XLEN-1:0]   logic_res;
  logic [XLEN-1:0]   shift_res;
  logic [XLEN-1:0]   arith_res;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   wdata;

  logic              mul_a_sgn;
  logic              mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] prod;

  logic              div_op;
  logic              div_signed;
  logic              div_want_rem;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic              div_ready;

  assign opv1  = bus.opv1_i;
  assign opv2  = bus.opv2_i;
  assign op    = bus.aluop_i;
  assign shamt = opv2[SH_W-1:0];
  assign known = aluop_known(op);

  always_comb begin
    logic_res = '0;
    case (op)
      EXE_AND: logic_res = opv1 & opv2;
      EXE_OR:  logic_res = opv1 | opv2;
      EXE_XOR: logic_res = opv1 ^ opv2;
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (op)
      EXE_SLL: shift_res = opv1 << shamt;
      EXE_SRL: shift_res = opv1 >> shamt;
      EXE_SRA: shift_res = XLEN'($signed(opv1) >>> shamt);
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (op)
      EXE_ADD:  arith_res = opv1 + opv2;
      EXE_SUB:  arith_res = opv1 - opv2;
      EXE_SLT:  arith_res = {{(XLEN-1){1'b0}}, ($signed(opv1) < $signed(opv2))};
      EXE_SLTU: arith_res = {{(XLEN-1){1'b0}}, (opv1 < opv2)};
      default:  arith_res = '0;
    endcase
  end

  // One shared 2*XLEN multiplier; per-op sign extension selects mulh/mulhsu/mulhu behaviour.
  always_comb begin
    mul_a_sgn = (op == EXE_MULH) || (op == EXE_MULHSU);
    mul_b_sgn = (op == EXE_MULH);
    mul_a_ext = {{XLEN{mul_a_sgn & opv1[XLEN-1]}}, opv1};
    mul_b_ext = {{XLEN{mul_b_sgn & opv2[XLEN-1]}}, opv2};
    prod      = mul_a_ext * mul_b_ext;
    mul_res   = '0;
    case (op)
      EXE_MUL:                        mul_res = prod[XLEN-1:0];
      EXE_MULH, EXE_MULHSU, EXE_MULHU: mul_res = prod[2*XLEN-1:XLEN];
      default:                        mul_res = '0;
    endcase
  end

  assign div_op       = (bus.alusel_i == RES_DIV) && is_div_op(op);
  assign div_signed   = (op == EXE_DIV) || (op == EXE_REM);
  assign div_want_rem = (op == EXE_REM) || (op == EXE_REMU);
  assign div_res      = div_want_rem ? div_r : div_q;

  ex_div #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op),
    .signed_op (div_signed),
    .hold      (bus.stall[3]),
    .dividend  (opv1),
    .divisor   (opv2),
    .quotient  (div_q),
    .remainder (div_r),
    .ready     (div_ready)
  );

  always_comb begin
    wdata = '0;
    case (bus.alusel_i)
      RES_LOGIC: wdata = logic_res;
      RES_SHIFT: wdata = shift_res;
      RES_ARITH: wdata = arith_res;
      RES_MUL:   wdata = mul_res;
      RES_DIV:   wdata = (div_op && div_ready) ? div_res : '0;
      RES_JUMP:  wdata = bus.link_addr_i;
      default:   wdata = '0;
    endcase
    if (!known) wdata = '0;
  end

  // Every output is forced to zero while reset is asserted, even with a live instruction in EX.
  assign bus.wdata_o     = rst ? wdata : '0;
  assign bus.we_o        = rst & bus.we_i & known;
  assign bus.reg_waddr_o = rst ? bus.reg_waddr_i : '0;
  assign bus.aluop_o     = rst ? op : '0;
  assign bus.mem_addr_o  = rst ? (opv1 + bus.mem_offset_i) : '0;
  assign bus.mem_data_o  = rst ? opv2 : '0;
  assign bus.stallreq_o  = rst & div_op & ~div_ready;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ops against a
// reference model, and multi-cycle divide / stall-hold / reset sequences.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    alu_op_t     op;
    alu_sel_t    sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] link;
    logic [31:0] off;
    logic [31:0] exp_wd;
    logic        exp_we;
    string       name;
  } vec_t;

  vec_t vecs[$];
  alu_op_t comb_ops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic drive(input alu_op_t op, input alu_sel_t sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] link, input logic [31:0] off);
    bus.aluop_i      = op;
    bus.alusel_i     = sel;
    bus.opv1_i       = a;
    bus.opv2_i       = b;
    bus.link_addr_i  = link;
    bus.mem_offset_i = off;
    bus.reg_waddr_i  = 5'd9;
    bus.we_i         = 1'b1;
  endtask

  function automatic alu_sel_t sel_of(input alu_op_t op);
    case (op)
      EXE_AND, EXE_OR, EXE_XOR:                    return RES_LOGIC;
      EXE_SLL, EXE_SRL, EXE_SRA:                   return RES_SHIFT;
      EXE_ADD, EXE_SUB, EXE_SLT, EXE_SLTU:         return RES_ARITH;
      EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU:    return RES_MUL;
      EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU:        return RES_DIV;
      EXE_JAL, EXE_JALR:                           return RES_JUMP;
      EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU,
      EXE_SB, EXE_SH, EXE_SW:                      return RES_LOADSTORE;
      default:                                     return RES_NOP;
    endcase
  endfunction

  // Reference for single-cycle ops, using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_comb(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] link);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      EXE_AND:    return a & b;
      EXE_OR:     return a | b;
      EXE_XOR:    return a ^ b;
      EXE_SLL:    return a << b[4:0];
      EXE_SRL:    return a >> b[4:0];
      EXE_SRA:    return 32'(sa >>> b[4:0]);
      EXE_ADD:    return a + b;
      EXE_SUB:    return a - b;
      EXE_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      EXE_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      EXE_MUL:    return 32'(sa * sb);
      EXE_MULH:   return 32'((sa * sb) >> 32);
      EXE_MULHSU: return 32'((longint'(sa) * longint'(ub)) >> 32);
      EXE_MULHU:  return 32'((ua * ub) >> 32);
      EXE_JAL, EXE_JALR: return link;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic div_fast(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == EXE_DIV) || (op == EXE_REM);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] q, r;
    sgn = (op == EXE_DIV) || (op == EXE_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((op == EXE_DIV) || (op == EXE_DIVU)) ? q : r;
  endfunction

  // Issues a divide on the next cycle, counts stallreq cycles (bounded), checks the
  // result, then optionally holds MEM for `hold` cycles and checks the result persists.
  task automatic run_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    int n;
    int want_n;
    n = 0;
    want_n = div_fast(op, a, b) ? 1 : 33;
    @(posedge clk); #1;
    drive(op, RES_DIV, a, b, 32'd0, 32'd0);
    @(negedge clk);
    while (bus.stallreq_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall cycles"}, 32'(n), 32'(want_n));
    check({tag, " result"}, bus.wdata_o, ref_div(op, a, b));
    if (hold > 0) begin
      bus.stall = 6'b001000;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, " held result"}, bus.wdata_o, ref_div(op, a, b));
        check({tag, " held stallreq"}, 32'(bus.stallreq_o), 32'd0);
      end
      bus.stall = 6'd0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wdata"},     bus.wdata_o, 32'd0);
    check({tag, " we"},        32'(bus.we_o), 32'd0);
    check({tag, " waddr"},     32'(bus.reg_waddr_o), 32'd0);
    check({tag, " aluop"},     32'(bus.aluop_o), 32'd0);
    check({tag, " mem_addr"},  bus.mem_addr_o, 32'd0);
    check({tag, " mem_data"},  bus.mem_data_o, 32'd0);
    check({tag, " stallreq"},  32'(bus.stallreq_o), 32'd0);
  endtask

  initial begin
    vecs.push_back('{EXE_SUB,    RES_ARITH,     32'd5,          32'd7,          32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, "sub"});
    vecs.push_back('{EXE_SRA,    RES_SHIFT,     32'h8000_0000,  32'd4,          32'd0, 32'd0, 32'hF800_0000, 1'b1, "sra"});
    vecs.push_back('{EXE_MULH,   RES_MUL,       32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd0, 32'h0000_0000, 1'b1, "mulh"});
    vecs.push_back('{EXE_MULHU,  RES_MUL,       32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1, "mulhu"});
    vecs.push_back('{EXE_MULHSU, RES_MUL,       32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, "mulhsu"});
    vecs.push_back('{EXE_MUL,    RES_MUL,       32'd3,          32'hFFFF_FFFE,  32'd0, 32'd0, 32'hFFFF_FFFA, 1'b1, "mul"});
    vecs.push_back('{EXE_AND,    RES_LOGIC,     32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 32'd0, 32'hF000_F000, 1'b1, "and"});
    vecs.push_back('{EXE_OR,     RES_LOGIC,     32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 32'd0, 32'hFFF0_FFF0, 1'b1, "or"});
    vecs.push_back('{EXE_XOR,    RES_LOGIC,     32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0, 32'd0, 32'h0FF0_0FF0, 1'b1, "xor"});
    vecs.push_back('{EXE_SLL,    RES_SHIFT,     32'd1,          32'h0000_0023,  32'd0, 32'd0, 32'h0000_0008, 1'b1, "sll"});
    vecs.push_back('{EXE_SRL,    RES_SHIFT,     32'h8000_0000,  32'd4,          32'd0, 32'd0, 32'h0800_0000, 1'b1, "srl"});
    vecs.push_back('{EXE_SLT,    RES_ARITH,     32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0, 32'h0000_0001, 1'b1, "slt"});
    vecs.push_back('{EXE_SLTU,   RES_ARITH,     32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0, 32'h0000_0000, 1'b1, "sltu"});
    vecs.push_back('{EXE_ADD,    RES_ARITH,     32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0, 32'h0000_0000, 1'b1, "add"});
    vecs.push_back('{EXE_JAL,    RES_JUMP,      32'd0,          32'd0,  32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1, "jal"});
    vecs.push_back('{EXE_SW,     RES_LOADSTORE, 32'h0000_1000,  32'hDEAD_BEEF,  32'd0, 32'hFFFF_FFFC, 32'd0, 1'b1, "sw"});
    vecs.push_back('{EXE_NOP,    RES_NOP,       32'd3,          32'd4,          32'd0, 32'd0, 32'd0, 1'b1, "nop"});
    vecs.push_back('{8'hFF,      RES_LOGIC,     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd0, 32'd0, 1'b0, "unknown"});

    comb_ops = '{EXE_AND, EXE_OR, EXE_XOR, EXE_SLL, EXE_SRL, EXE_SRA, EXE_ADD, EXE_SUB,
                 EXE_SLT, EXE_SLTU, EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU, EXE_JAL,
                 EXE_JALR, EXE_LW, EXE_SB, EXE_NOP};

    bus.stall = 6'd0;
    drive(EXE_ADD, RES_ARITH, 32'd1, 32'd2, 32'd3, 32'd4);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].link, vecs[i].off);
      @(negedge clk);
      check({vecs[i].name, " wdata"},    bus.wdata_o, vecs[i].exp_wd);
      check({vecs[i].name, " we"},       32'(bus.we_o), 32'(vecs[i].exp_we));
      check({vecs[i].name, " stallreq"}, 32'(bus.stallreq_o), 32'd0);
      check({vecs[i].name, " mem_addr"}, bus.mem_addr_o, vecs[i].a + vecs[i].off);
      check({vecs[i].name, " mem_data"}, bus.mem_data_o, vecs[i].b);
      check({vecs[i].name, " aluop"},    32'(bus.aluop_o), 32'(vecs[i].op));
      check({vecs[i].name, " waddr"},    32'(bus.reg_waddr_o), 32'd9);
    end

    for (int i = 0; i < 200; i++) begin
      alu_op_t     op;
      alu_sel_t    sel;
      logic [31:0] a, b, link, off;
      logic        unk;
      unk  = ($urandom_range(0, 9) == 0);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      link = $urandom;
      off  = $urandom;
      if (unk) begin
        op  = 8'($urandom_range(32'h1D, 32'hFF));
        sel = 3'($urandom_range(0, 7));
      end else begin
        op  = comb_ops[$urandom_range(0, comb_ops.size() - 1)];
        sel = sel_of(op);
      end
      @(posedge clk); #1;
      drive(op, sel, a, b, link, off);
      @(negedge clk);
      check("rand wdata",    bus.wdata_o, unk ? 32'd0 : ref_comb(op, a, b, link));
      check("rand we",       32'(bus.we_o), unk ? 32'd0 : 32'd1);
      check("rand mem_addr", bus.mem_addr_o, a + off);
    end

    run_div(EXE_DIV,  32'hFFFF_FFF9, 32'd2,          0, "div -7/2");
    run_div(EXE_REM,  32'hFFFF_FFF9, 32'd2,          0, "rem -7/2");
    run_div(EXE_DIVU, 32'd10,        32'd0,          0, "divu by 0");
    run_div(EXE_REM,  32'h8000_0000, 32'hFFFF_FFFF,  0, "rem ovf");
    run_div(EXE_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  0, "div ovf");
    run_div(EXE_DIV,  32'd1000,      32'd7,          4, "div hold");
    run_div(EXE_DIV,  32'd12345,     32'hFFFF_FFFD,  0, "div b2b");
    run_div(EXE_REMU, 32'hFFFF_FFFF, 32'd16,         0, "remu");

    // Reset asserted for three cycles in the middle of a division.
    @(posedge clk); #1;
    drive(EXE_DIV, RES_DIV, 32'd100, 32'd7, 32'd0, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("mid-div reset");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(EXE_NOP, RES_NOP, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("post-reset stallreq", 32'(bus.stallreq_o), 32'd0);
    run_div(EXE_DIV, 32'd100, 32'd7, 0, "post-reset div");

    for (int i = 0; i < 8; i++) begin
      alu_op_t     op;
      logic [31:0] a, b;
      case ($urandom_range(0, 3))
        0: op = EXE_DIV;
        1: op = EXE_DIVU;
        2: op = EXE_REM;
        default: op = EXE_REMU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      run_div(op, a, b, (i == 3) ? 2 : 0, "rand div");
    end

    @(posedge clk); #1;
    drive(EXE_NOP, RES_NOP, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("final stallreq", 32'(bus.stallreq_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline, sitting between the ID/EX pipeline register and the EX/MEM pipeline register.
- Computes ALU, shift, compare, multiply, jump-link and load/store address results from the ID/EX outputs.
- Integer divide/remainder runs on an iterative radix-2 divider. The divider raises stallreq so the controller freezes IF/ID/EX until the result is ready.

Parameters:
- XLEN, 32, datapath width; all operand and result buses are XLEN bits.
- DIV_CYCLES, 32, iteration count of the divider (equals XLEN).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- aluop_i  in  `AluOpBus  operation code from ID/EX
- alusel_i  in  `AluSelBus  result class from ID/EX
- opv1_i  in  `RegBus  operand 1
- opv2_i  in  `RegBus  operand 2 (store data for stores)
- reg_waddr_i  in  `RegAddrBus  destination register
- we_i  in  1  register write enable
- link_addr_i  in  `InstAddrBus  return address for JAL/JALR
- mem_offset_i  in  `RegBus  sign-extended load/store offset
- stall  in  6  controller stall vector; bit 3 = MEM stage held
- reg_waddr_o  out  `RegAddrBus  destination register to EX/MEM
- we_o  out  1  write enable to EX/MEM
- wdata_o  out  `RegBus  result
- aluop_o  out  `AluOpBus  aluop passed through for MEM
- mem_addr_o  out  `RegBus  opv1_i + mem_offset_i
- mem_data_o  out  `RegBus  opv2_i
- stallreq_o  out  1  request to freeze stages up to EX

Behaviour:
- While rst==0, all outputs are 0 and the divider FSM is forced to IDLE with operands and result cleared. This applies both at reset and mid-division.
- Non-divide classes are combinational, zero added latency:
  - LOGIC: and, or, xor.
  - SHIFT: sll, srl, sra by opv2[4:0].
  - ARITH: add, sub, slt (signed), sltu.
  - MUL: mul, mulh, mulhsu, mulhu; low or high 32 bits of a 64-bit product, with signedness per op.
  - JUMP: wdata = link_addr_i.
  - LOADSTORE: wdata = 0; mem_addr_o and mem_data_o are valid.
  - NOP: wdata = 0.
- Unknown aluop: wdata = 0, we_o = 0.
- DIV class (div, divu, rem, remu), FSM states IDLE, BUSY, DONE:
  - IDLE with a DIV-class op present: latch the absolute values (for signed ops) and the sign flags.
    - Divisor == 0: go to DONE with quotient = 0xFFFFFFFF and remainder = dividend.
    - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE with quotient = 0x80000000 and remainder = 0.
    - Otherwise: go to BUSY with the counter at 0.
  - BUSY: one restoring shift-subtract step per cycle. After DIV_CYCLES steps, apply the sign fix-up (quotient negated if the operand signs differ; remainder takes the dividend's sign) and go to DONE.
  - DONE: wdata = quotient (div, divu) or remainder (rem, remu).
    - Go to IDLE on the next edge if stall[3]==0.
    - Stay in DONE while stall[3]==1.
  - stallreq_o = 1 when a DIV-class op is present and the state is IDLE or BUSY; otherwise 0.
  - Latency, normal case: stallreq_o is high for 33 cycles; the result is on wdata_o in cycle 34.
  - Latency, fast paths: stallreq_o is high for 1 cycle; the result appears in cycle 2.
  - Inputs are ignored while BUSY; the latched operands are used.
  - A new DIV op arriving in the cycle after DONE (back-to-back divides) starts a fresh division from IDLE.
- reg_waddr_o, we_o and aluop_o pass through the corresponding inputs combinationally, except for the unknown-aluop rule above.

Decomposition:
- defines.v holds all shared constants: `RegBus, `AluOpBus, `AluSelBus, `RegAddrBus, `InstAddrBus, the EXE_* aluop codes and the RES_* alusel codes. Widths for the M-extension ops are added there.
- Divider FSM state encodings stay local to the sub-module.
- One sub-module: ex_div (iterative signed/unsigned divider).
  - Inputs: clk, rst, start, signed_op, dividend, divisor.
  - Outputs: quotient, remainder, ready.
  - ready is high in DONE; ex_stage drives the hold (stall[3]) into it.

Test Plan:
- Reset held low for 3 cycles during a BUSY divide -> all outputs 0; after release the FSM is in IDLE and stallreq_o = 0.
- ARITH sub with opv1=5, opv2=7 -> wdata = 0xFFFFFFFE. SHIFT sra with opv1=0x80000000, opv2=4 -> wdata = 0xF8000000. Both in the same cycle, with stallreq_o = 0.
- MUL mulh with opv1=0xFFFFFFFF, opv2=0xFFFFFFFF -> 0x00000000. mulhu with the same operands -> 0xFFFFFFFE.
- DIV with opv1=-7, opv2=2 -> stallreq_o high for 33 cycles, then wdata = 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- DIVU with opv1=10, opv2=0 -> stallreq_o high for 1 cycle, wdata = 0xFFFFFFFF. REM with opv1=0x80000000, opv2=-1 -> wdata = 0.
- DIV completes while stall[3]=1 for 4 cycles -> the result holds on wdata_o with stallreq_o = 0. A second, back-to-back DIV issued after release restarts the full 33-cycle sequence.
